// File: rtl/des_block_streamer.sv
// rtl/des_block_streamer.sv - streams 64-bit blocks from a byte-wide memory to a DES core and writes results back in place
module des_block_streamer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int BLK_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [3:0]                  num_blocks,
  output logic                        mem_en,
  output logic                        mem_wr0,
  output logic [ADDR_W-1:0]           mem_add0,
  input  logic [DATA_W-1:0]           mem_rdata0,
  output logic                        mem_wr1,
  output logic [ADDR_W-1:0]           mem_add1,
  output logic [DATA_W-1:0]           mem_wdata1,
  output logic [BLK_BYTES*DATA_W-1:0] blk_out,
  output logic                        blk_out_valid,
  input  logic                        blk_out_ready,
  input  logic [BLK_BYTES*DATA_W-1:0] blk_in,
  input  logic                        blk_in_valid,
  output logic                        blk_in_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int BLK_W = BLK_BYTES * DATA_W;

  typedef enum logic [2:0] {
    IDLE, FETCH, PRESENT, WAIT_RES, WRITE, DONE
  } state_t;

  state_t            state, nxt;
  logic [3:0]        cnt;
  logic [3:0]        remaining;
  logic [ADDR_W-1:0] blk_addr;
  logic [BLK_W-1:0]  asm_reg;
  logic [BLK_W-1:0]  res_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = (num_blocks == 4'd0) ? DONE : FETCH;
      FETCH:    if (cnt == 4'(BLK_BYTES)) nxt = PRESENT;
      PRESENT:  if (blk_out_ready) nxt = WAIT_RES;
      WAIT_RES: if (blk_in_valid) nxt = WRITE;
      WRITE:    if (cnt == 4'(BLK_BYTES - 1)) nxt = (remaining == 4'd1) ? DONE : FETCH;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so FETCH runs one cycle past the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      remaining  <= '0;
      blk_addr   <= '0;
      asm_reg    <= '0;
      res_reg    <= '0;
      mem_add1   <= '0;
      mem_wdata1 <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          blk_addr  <= base_addr;
          remaining <= num_blocks;
          cnt       <= '0;
        end
        FETCH: begin
          if (cnt != 4'd0) asm_reg <= {asm_reg[BLK_W-DATA_W-1:0], mem_rdata0};
          cnt <= (cnt == 4'(BLK_BYTES)) ? 4'd0 : cnt + 4'd1;
        end
        WAIT_RES: if (blk_in_valid) begin
          res_reg    <= {blk_in[BLK_W-DATA_W-1:0], {DATA_W{1'b0}}};
          mem_add1   <= blk_addr;
          mem_wdata1 <= blk_in[BLK_W-1 -: DATA_W];
          cnt        <= '0;
        end
        WRITE: begin
          if (cnt == 4'(BLK_BYTES - 1)) begin
            cnt       <= '0;
            blk_addr  <= blk_addr + ADDR_W'(BLK_BYTES);
            remaining <= remaining - 4'd1;
          end else begin
            cnt        <= cnt + 4'd1;
            mem_add1   <= mem_add1 + ADDR_W'(1);
            mem_wdata1 <= res_reg[BLK_W-1 -: DATA_W];
            res_reg    <= {res_reg[BLK_W-DATA_W-1:0], {DATA_W{1'b0}}};
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_add0      = blk_addr + ADDR_W'(cnt);
  assign mem_wr0       = 1'b1;
  assign mem_en        = (state == FETCH) || (state == PRESENT) ||
                         (state == WAIT_RES) || (state == WRITE);
  assign mem_wr1       = (state != WRITE);
  assign blk_out       = asm_reg;
  assign blk_out_valid = (state == PRESENT);
  assign blk_in_ready  = (state == WAIT_RES);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_des_block_streamer.sv
// tb/tb_des_block_streamer.sv - directed self-checking bench for des_block_streamer
module tb_des_block_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [3:0]  num_blocks = '0;
  logic        mem_en, mem_wr0, mem_wr1;
  logic [5:0]  mem_add0, mem_add1;
  logic [7:0]  mem_rdata0;
  logic [7:0]  mem_wdata1;
  logic [63:0] blk_out;
  logic        blk_out_valid;
  logic        blk_out_ready = 1'b0;
  logic [63:0] blk_in = '0;
  logic        blk_in_valid = 1'b0;
  logic        blk_in_ready, busy, done;

  logic [7:0]  mem [64];
  logic        init_req = 1'b0;
  int          checks = 0;
  int          errors = 0;

  des_block_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .mem_en(mem_en), .mem_wr0(mem_wr0), .mem_add0(mem_add0), .mem_rdata0(mem_rdata0),
    .mem_wr1(mem_wr1), .mem_add1(mem_add1), .mem_wdata1(mem_wdata1),
    .blk_out(blk_out), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
    .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Dual-port memory model: registered read on port 0, active-low write on port 1.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (mem_en) begin
      mem_rdata0 <= mem[mem_add0];
      if (!mem_wr1) mem[mem_add1] <= mem_wdata1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem64(input logic [5:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], mem[6'(a + 6'(i))]};
    return v;
  endfunction

  task automatic init_mem();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic kick(input logic [5:0] b, input logic [3:0] n);
    base_addr = b; num_blocks = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_wr0"}, 64'(mem_wr0), 64'd1);
    chk({tag, "_wr1"}, 64'(mem_wr1), 64'd1);
    chk({tag, "_add0"}, 64'(mem_add0), 64'd0);
    chk({tag, "_add1"}, 64'(mem_add1), 64'd0);
    chk({tag, "_wdata1"}, 64'(mem_wdata1), 64'd0);
    chk({tag, "_blk_out"}, blk_out, 64'd0);
    chk({tag, "_flags"}, {60'd0, blk_out_valid, blk_in_ready, busy, done}, 64'd0);
  endtask

  // Runs one block from the PRESENT wait through wr_cycles write cycles.
  task automatic do_block(input logic [63:0] exp_out, input logic [63:0] res, input int rdy_delay,
                          input int vld_delay, input logic [5:0] b, input int wr_cycles);
    int n;
    n = 0;
    while (!blk_out_valid && n < 40) begin tick(); n++; end
    chk("valid_seen", 64'(blk_out_valid), 64'd1);
    chk("blk_out", blk_out, exp_out);
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      chk("bp_blk_out", blk_out, exp_out);
      chk("bp_valid_wr1", {62'd0, blk_out_valid, mem_wr1}, 64'd3);
    end
    blk_out_ready = 1'b1;
    tick();
    blk_out_ready = 1'b0;
    for (int i = 0; i < vld_delay; i++) begin
      chk("wait_ready_wr1", {62'd0, blk_in_ready, mem_wr1}, 64'd3);
      tick();
    end
    chk("in_ready", 64'(blk_in_ready), 64'd1);
    blk_in = res; blk_in_valid = 1'b1;
    tick();
    blk_in_valid = 1'b0;
    for (int i = 0; i < wr_cycles; i++) begin
      chk("wr_strobe", {62'd0, mem_wr1, blk_in_ready}, 64'd0);
      chk("wr_addr", 64'(mem_add1), 64'(6'(b + 6'(i))));
      chk("wr_data", 64'(mem_wdata1), 64'(res[63 - 8*i -: 8]));
      tick();
    end
  endtask

  initial begin
    int n;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    init_mem();

    // Single block with latency measurement
    kick(6'd0, 4'd1);
    chk("first_rd_addr", {56'd0, mem_en, 1'b0, mem_add0}, {56'd0, 2'b10, 6'd0});
    n = 0;
    while (!blk_out_valid && n < 40) begin tick(); n++; end
    chk("start_to_valid", 64'(n), 64'd9);
    do_block(64'h0001020304050607, 64'hF0E1D2C3B4A59687, 0, 0, 6'd0, 8);
    chk("done1", {61'd0, done, busy, mem_wr1}, 64'd7);
    tick();
    chk("after_done1", {62'd0, done, busy}, 64'd0);
    chk("mem_single", mem64(6'd0), 64'hF0E1D2C3B4A59687);

    // Wrap-around, backpressure and an ignored start
    init_mem();
    kick(6'd60, 4'd2);
    chk("wrap_rd_addr", 64'(mem_add0), 64'd60);
    base_addr = 6'd20; num_blocks = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    do_block(64'h3C3D3E3F00010203, 64'h1021324354657687, 5, 3, 6'd60, 8);
    chk("next_rd_addr", {56'd0, mem_en, 1'b0, mem_add0}, {56'd0, 2'b10, 6'd4});
    do_block(64'h0405060708090A0B, 64'h8877665544332211, 0, 0, 6'd4, 8);
    chk("done2", 64'(done), 64'd1);
    tick();
    chk("mem_wrap_a", mem64(6'd60), 64'h1021324354657687);
    chk("mem_wrap_b", mem64(6'd4), 64'h8877665544332211);
    chk("mem_untouched", 64'(mem[12]), 64'h0C);

    // Zero blocks
    kick(6'd7, 4'd0);
    chk("zero_done", {61'd0, done, busy, mem_en}, 64'd6);
    tick();
    chk("zero_after", {61'd0, done, busy, mem_en}, 64'd0);

    // Reset during the write phase
    init_mem();
    kick(6'd16, 4'd1);
    do_block(64'h1011121314151617, 64'h1122334455667788, 0, 0, 6'd16, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_mem", mem64(6'd16), 64'h1122331314151617);

    kick(6'd16, 4'd1);
    do_block(64'h1122331314151617, 64'hAABBCCDDEEFF0011, 1, 1, 6'd16, 8);
    chk("fresh_done", 64'(done), 64'd1);
    tick();
    chk("fresh_mem", mem64(6'd16), 64'hAABBCCDDEEFF0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_block_streamer.md
# des_block_streamer

Block streamer between the 64x8 dual-port DES data memory and the DES core. On `start`, it reads `num_blocks` 64-bit blocks from the memory byte by byte on port 0 and presents each block to the core over a valid/ready handshake. It then accepts the core's 64-bit result and writes it back in place through port 1. Blocks are processed strictly serially, one in flight.

## Interface
- `ADDR_W`, 6: memory address width (64 bytes).
- `DATA_W`, 8: memory byte width.
- `BLK_BYTES`, 8: bytes per DES block. Fixed at 8; other values are not supported.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in 6: byte address of the first block; sampled with `start`.
- `num_blocks` in 4: number of blocks to process (0..8); sampled with `start`.
- `mem_en` out 1: memory enable.
- `mem_wr0` out 1: port-0 write strobe, active-low. Held at 1, so port 0 only reads.
- `mem_add0` out 6: port-0 read address.
- `mem_rdata0` in 8: port-0 registered read data, valid one cycle after the address is sampled.
- `mem_wr1` out 1: port-1 write strobe, active-low.
- `mem_add1` out 6: port-1 write address.
- `mem_wdata1` out 8: port-1 write data.
- `blk_out` out 64: block to the core. Lowest-address byte is in [63:56].
- `blk_out_valid` out 1 / `blk_out_ready` in 1: downstream handshake.
- `blk_in` in 64: result from the core. [63:56] goes to the lowest address.
- `blk_in_valid` in 1 / `blk_in_ready` out 1: result handshake.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- **States:** IDLE, FETCH, PRESENT, WAIT_RES, WRITE, DONE.
- **IDLE:**
  - On `start`, latch `blk_addr = base_addr` and `remaining = num_blocks`.
  - If `num_blocks` is 0, go to DONE; otherwise go to FETCH.
  - A `start` received in any state other than IDLE is ignored.
- **FETCH:**
  - Issue 8 reads at `blk_addr+i`, for i = 0..7, one per cycle.
  - Capture each byte from `mem_rdata0` one cycle after it is sampled, shifting it into the assembly register.
  - After byte 7 is captured, go to PRESENT.
- **PRESENT:**
  - Hold `blk_out` and `blk_out_valid = 1` stable until `blk_out_ready = 1`, then go to WAIT_RES.
- **WAIT_RES:**
  - Hold `blk_in_ready = 1`.
  - On `blk_in_valid = 1`, latch `blk_in` and go to WRITE.
- **WRITE:**
  - For 8 cycles, drive `mem_wr1 = 0`, `mem_add1 = blk_addr+i` and `mem_wdata1 = byte i`.
  - Then set `blk_addr += 8` and `remaining -= 1`.
  - If `remaining` is nonzero, go to FETCH; otherwise go to DONE.
- **DONE:** pulse `done` for one cycle, then go to IDLE.
- **Address arithmetic:** all address arithmetic is modulo 64. A block starting at 60 covers bytes 60..63 and then 0..3, and the next block starts at 4.
- **Memory enable:** `mem_en = 1` in FETCH through WRITE, and 0 in IDLE and DONE.
- **Port 1 outside writes:** outside WRITE, `mem_wr1 = 1` and `mem_add1` holds its last value. Port-1 reads are don't-care.
- **No port conflicts:** FETCH and WRITE never overlap, so there are no same-address read/write conflicts.

## Timing
- **Reset values:** while `rst_n = 0`, all outputs are forced immediately:
  - `mem_en = 0`, `mem_wr0 = 1`, `mem_wr1 = 1`.
  - `mem_add0`, `mem_add1` and `mem_wdata1` = 0.
  - `blk_out` = 0, `blk_out_valid` = 0, `blk_in_ready` = 0.
  - `busy` = 0, `done` = 0.
  - The FSM goes to IDLE.
- **Reset mid-job:** the job is abandoned and no further writes are issued. Bytes already written stay in memory.
- **Start to valid:** `start` is sampled at edge E0.
  - Read address i is driven in cycle i+1 and sampled by memory at edge E(i+1).
  - Byte i is captured at E(i+2).
  - `blk_out_valid` rises after E9: 9 cycles from `start`.
- **Back-to-back handshakes:** `blk_out_ready` high at the edge where `blk_out_valid` is first seen gives a 1-cycle PRESENT. `blk_in_valid` already high gives a 1-cycle WAIT_RES.
- **Writes:** occupy exactly 8 cycles. The first write strobe is driven in the cycle after the result is accepted.
- **Between blocks:** the next block's first read address is driven in the cycle after the last write.
- **`done`:** high for exactly one cycle, in the cycle after the final write. `busy` falls together with `done`.
- **Zero blocks:** `num_blocks = 0` gives `done` in the cycle after `start`, with no memory access and `mem_en` staying 0.
- **Handshake stability:** `blk_out` is stable whenever `blk_out_valid = 1`. `blk_in_ready` is high only in WAIT_RES.

## Test plan
- **Single block:** preload mem[0..7] = 00..07; `start` with `base_addr` 0 and `num_blocks` 1.
  - `blk_out` = 0x0001020304050607, with valid exactly 9 cycles after `start`.
  - Return `blk_in` = 0xF0E1D2C3B4A59687 → mem[0..7] = F0 E1 D2 C3 B4 A5 96 87, then a `done` pulse.
- **Wrap-around:** `base_addr` 60, `num_blocks` 2, with mem[i] = i.
  - First block is 0x3C3D3E3F00010203; second block is 0x0405060708090A0B.
  - Writes land at 60..63, 0..3 and then 4..11.
- **Backpressure:** hold `blk_out_ready` = 0 for 5 cycles and delay `blk_in_valid` by 3 cycles.
  - `blk_out` stays stable, no memory writes occur, and `blk_in_ready` stays high until accepted.
- **Zero blocks and ignored start:** `num_blocks` = 0 → `done` one cycle after `start`, with `mem_en` staying 0.
  - A `start` pulsed while busy has no effect on the address sequence.
- **Reset mid-write:** assert `rst_n` = 0 after the third write byte.
  - Outputs go immediately to their reset values, and bytes 3..7 are unchanged.
  - A subsequent fresh `start` runs correctly.
